// File: rtl/srt_div_unit.sv
// Radix-2 non-restoring integer divider with valid/ready handshakes, signed or
// unsigned operands per request, early-out special cases and a flush input.
module srt_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             usigned,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] reminder,
  output logic             div_by_zero,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_CORRECT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        dvd_q, dvd_d;
  logic [WIDTH-1:0]        dvs_q, dvs_d;
  logic                    usg_q, usg_d;
  logic signed [WIDTH:0]   prem_q, prem_d;
  logic signed [WIDTH:0]   dmag_q, dmag_d;
  logic [WIDTH-1:0]        qacc_q, qacc_d;
  logic                    qneg_q, qneg_d;
  logic                    rneg_q, rneg_d;
  logic [WIDTH-1:0]        quotient_q, quotient_d;
  logic [WIDTH-1:0]        reminder_q, reminder_d;
  logic                    dbz_q, dbz_d;
  logic                    ovf_q, ovf_d;

  logic signed [WIDTH:0]   shifted_rem;
  logic signed [WIDTH:0]   step_rem;
  logic signed [WIDTH:0]   fixed_rem;
  logic                    is_dbz;
  logic                    is_ovf;

  // MIN maps to 2^(WIDTH-1), which is still representable as an unsigned value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic            is_signed);
    return (is_signed && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x,
                                                  input logic            neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  // Arithmetic wraps modulo 2^(WIDTH+1); the true step result always lies in
  // [-divisor, divisor) and therefore fits the partial-remainder register.
  always_comb begin
    shifted_rem = {prem_q[WIDTH-1:0], qacc_q[WIDTH-1]};
    step_rem    = prem_q[WIDTH] ? (shifted_rem + dmag_q) : (shifted_rem - dmag_q);
    fixed_rem   = prem_q[WIDTH] ? (prem_q + dmag_q) : prem_q;
    is_dbz      = (dvs_q == '0);
    is_ovf      = !usg_q && (dvd_q == MIN_VAL) && (dvs_q == ALL_ONES);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    usg_d      = usg_q;
    prem_d     = prem_q;
    dmag_d     = dmag_q;
    qacc_d     = qacc_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    quotient_d = quotient_q;
    reminder_d = reminder_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            usg_d   = usigned;
            dbz_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          prem_d = '0;
          qacc_d = magnitude(dvd_q, !usg_q);
          dmag_d = {1'b0, magnitude(dvs_q, !usg_q)};
          qneg_d = !usg_q && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          rneg_d = !usg_q && dvd_q[WIDTH-1];
          cnt_d  = CNT_LOAD;
          if (is_dbz) begin
            quotient_d = ALL_ONES;
            reminder_d = dvd_q;
            dbz_d      = 1'b1;
            state_d    = S_DONE;
          end else if (is_ovf) begin
            quotient_d = MIN_VAL;
            reminder_d = '0;
            ovf_d      = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d = S_ITER;
          end
        end
        S_ITER: begin
          prem_d = step_rem;
          qacc_d = {qacc_q[WIDTH-2:0], ~step_rem[WIDTH]};
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_CORRECT;
          end
        end
        S_CORRECT: begin
          // Quotient bits already follow the true remainder sign; only the
          // remainder needs restoring when the last step went negative.
          quotient_d = apply_sign(qacc_q, qneg_q);
          reminder_d = apply_sign(fixed_rem[WIDTH-1:0], rneg_q);
          state_d    = S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      usg_q      <= 1'b0;
      prem_q     <= '0;
      dmag_q     <= '0;
      qacc_q     <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      quotient_q <= '0;
      reminder_q <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      usg_q      <= usg_d;
      prem_q     <= prem_d;
      dmag_q     <= dmag_d;
      qacc_q     <= qacc_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      quotient_q <= quotient_d;
      reminder_q <= reminder_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign quotient    = quotient_q;
  assign reminder    = reminder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_srt_div_unit.sv
// Bench for srt_div_unit: a 32-bit instance for directed/table/random checks and
// an 8-bit instance for boundary sweeps, random stalls and async resets.
module tb_srt_div_unit;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst32, iv32, us32, fl32, or32;
  logic [31:0] a32, b32, q32, r32;
  logic        ir32, vld32, dz32, of32, bz32;

  srt_div_unit #(.WIDTH(32)) u_div32 (
    .clk(clk), .rst_n(rst32), .in_valid(iv32), .in_ready(ir32), .usigned(us32),
    .dividend(a32), .divisor(b32), .flush(fl32), .out_valid(vld32),
    .out_ready(or32), .quotient(q32), .reminder(r32), .div_by_zero(dz32),
    .overflow(of32), .busy(bz32));

  // 8-bit instance
  logic        rst8, iv8, us8, fl8, or8;
  logic [7:0]  a8, b8, q8, r8;
  logic        ir8, vld8, dz8, of8, bz8;

  srt_div_unit #(.WIDTH(8)) u_div8 (
    .clk(clk), .rst_n(rst8), .in_valid(iv8), .in_ready(ir8), .usigned(us8),
    .dividend(a8), .divisor(b8), .flush(fl8), .out_valid(vld8),
    .out_ready(or8), .quotient(q8), .reminder(r8), .div_by_zero(dz8),
    .overflow(of8), .busy(bz8));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: truncating division on plain integers, special cases first.
  function automatic void model(input int w, input bit us,
                                input longint unsigned a, input longint unsigned b,
                                output longint unsigned q, output longint unsigned r,
                                output bit dz, output bit ov);
    longint unsigned mask;
    longint unsigned minv;
    longint sa, sb, sq, sr;
    mask = (64'd1 << w) - 64'd1;
    minv = 64'd1 << (w - 1);
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q = mask; r = a; dz = 1'b1;
    end else if (!us && a == minv && b == mask) begin
      q = minv; r = 0; ov = 1'b1;
    end else if (us) begin
      q = a / b; r = a % b;
    end else begin
      sa = (a >= minv) ? (longint'(a) - longint'(64'd1 << w)) : longint'(a);
      sb = (b >= minv) ? (longint'(b) - longint'(64'd1 << w)) : longint'(b);
      sq = sa / sb;
      sr = sa % sb;
      q = longint'(sq) & mask;
      r = longint'(sr) & mask;
    end
  endfunction

  // Issue one request on the 32-bit unit and wait for the result (out_ready held 0).
  task automatic run32(input bit us, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit to);
    chk("in_ready32_before_accept", {63'd0, ir32}, 64'd1);
    us32 = us; a32 = a; b32 = b; iv32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv32 = 1'b0;
    lat = 0;
    to = 1'b1;
    for (int i = 1; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (vld32) begin
        lat = i; to = 1'b0;
        break;
      end
    end
    if (to) begin
      n_vec++; n_bad++;
      $display("FAIL run32_timeout: out_valid never rose for %0h/%0h", a, b);
    end
  endtask

  task automatic release32();
    or32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or32 = 1'b0;
  endtask

  // 8-bit op with random out_ready stalls and occasional async reset.
  task automatic run8(input bit us, input logic [7:0] a, input logic [7:0] b,
                      input bit do_rst, input int rst_at);
    longint unsigned eq, er;
    bit edz, eov, seen, got;
    int guard;
    model(8, us, {56'd0, a}, {56'd0, b}, eq, er, edz, eov);
    guard = 0;
    while (!ir8 && guard < 10) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    if (!ir8) begin
      n_vec++; n_bad++;
      $display("FAIL in_ready8_timeout: in_ready stayed %0d", ir8);
      return;
    end
    us8 = us; a8 = a; b8 = b; iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    seen = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (do_rst && i == rst_at) begin
        #2 rst8 = 1'b0;
        #1;
        chk("async_rst8_out_valid", {63'd0, vld8}, 64'd0);
        chk("async_rst8_busy", {63'd0, bz8}, 64'd0);
        chk("async_rst8_in_ready", {63'd0, ir8}, 64'd1);
        chk("async_rst8_quotient", {56'd0, q8}, 64'd0);
        @(negedge clk);
        rst8 = 1'b1;
        or8 = 1'b0;
        return;
      end
      if (vld8) begin
        chk("q8", {56'd0, q8}, eq);
        chk("r8", {56'd0, r8}, er);
        if (!seen) begin
          chk("dz8", {63'd0, dz8}, {63'd0, edz});
          chk("ov8", {63'd0, of8}, {63'd0, eov});
          chk("in_ready8_in_done", {63'd0, ir8}, 64'd0);
        end
        seen = 1'b1;
        or8 = 1'($urandom_range(0, 1));
        if (or8) begin
          @(posedge clk);
          @(negedge clk);
          or8 = 1'b0;
          got = 1'b1;
          break;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!got) begin
      n_vec++; n_bad++;
      $display("FAIL run8_timeout: %0h/%0h us=%0d seen=%0d", a, b, us, seen);
    end
  endtask

  typedef struct {
    bit          us;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    bit          dz;
    bit          ov;
  } vec_t;

  initial begin
    vec_t tbl[12];
    int lat;
    bit to;
    bit leaked;
    logic [31:0] hold_q;
    longint unsigned eq, er;
    bit edz, eov;
    logic [7:0] edges[8];

    tbl[0]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0};
    tbl[1]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 1'b0};
    tbl[2]  = '{1'b0, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 1'b0};
    tbl[3]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1'b0};
    tbl[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1'b0};
    tbl[5]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b1};
    tbl[6]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 1'b0};
    tbl[7]  = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 1'b0};
    tbl[8]  = '{1'b0, 32'hFFFFFFF8,   32'd3,          32'hFFFFFFFE,   32'hFFFFFFFE,   1'b0, 1'b0};
    tbl[9]  = '{1'b0, 32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 1'b0};
    tbl[10] = '{1'b0, 32'd0,          32'hFFFFFFFB,   32'd0,          32'd0,          1'b0, 1'b0};
    tbl[11] = '{1'b1, 32'hFFFFFFFF,   32'd16,         32'h0FFFFFFF,   32'd15,         1'b0, 1'b0};

    rst32 = 1'b0; iv32 = 1'b0; us32 = 1'b0; fl32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0;
    rst8  = 1'b0; iv8  = 1'b0; us8  = 1'b0; fl8  = 1'b0; or8  = 1'b0; a8  = '0; b8  = '0;
    repeat (2) @(negedge clk);

    // reset values
    chk("rst_in_ready", {63'd0, ir32}, 64'd1);
    chk("rst_out_valid", {63'd0, vld32}, 64'd0);
    chk("rst_busy", {63'd0, bz32}, 64'd0);
    chk("rst_quotient", {32'd0, q32}, 64'd0);
    chk("rst_reminder", {32'd0, r32}, 64'd0);
    chk("rst_dbz", {63'd0, dz32}, 64'd0);
    chk("rst_ovf", {63'd0, of32}, 64'd0);
    chk("rst8_in_ready", {63'd0, ir8}, 64'd1);
    rst32 = 1'b1;
    rst8  = 1'b1;
    @(negedge clk);

    // table vectors with latency
    for (int i = 0; i < 12; i++) begin
      run32(tbl[i].us, tbl[i].a, tbl[i].b, lat, to);
      if (!to) begin
        chk($sformatf("tbl%0d_quotient", i), {32'd0, q32}, {32'd0, tbl[i].q});
        chk($sformatf("tbl%0d_reminder", i), {32'd0, r32}, {32'd0, tbl[i].r});
        chk($sformatf("tbl%0d_dbz", i), {63'd0, dz32}, {63'd0, tbl[i].dz});
        chk($sformatf("tbl%0d_ovf", i), {63'd0, of32}, {63'd0, tbl[i].ov});
        chk($sformatf("tbl%0d_latency", i), 64'(lat),
            (tbl[i].dz || tbl[i].ov) ? 64'd1 : 64'd34);
      end
      release32();
      chk($sformatf("tbl%0d_idle_after", i), {62'd0, ir32, vld32}, 64'd2);
    end

    // stall in DONE for 10 cycles
    run32(1'b1, 32'd100, 32'd7, lat, to);
    hold_q = q32;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_out_valid", {63'd0, vld32}, 64'd1);
      chk("stall_in_ready", {63'd0, ir32}, 64'd0);
      chk("stall_quotient", {32'd0, q32}, {32'd0, hold_q});
      chk("stall_reminder", {32'd0, r32}, 64'd2);
    end
    release32();
    chk("stall_release_idle", {63'd0, ir32}, 64'd1);

    // flush mid-ITER
    us32 = 1'b1; a32 = 32'd100; b32 = 32'd7; iv32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv32 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_flush_busy", {63'd0, bz32}, 64'd1);
    fl32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fl32 = 1'b0;
    chk("flush_in_ready", {63'd0, ir32}, 64'd1);
    chk("flush_busy", {63'd0, bz32}, 64'd0);
    leaked = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (vld32) leaked = 1'b1;
    end
    chk("flush_no_out_valid", {63'd0, leaked}, 64'd0);
    run32(1'b1, 32'hFFFFFFFF, 32'd1, lat, to);
    chk("post_flush_quotient", {32'd0, q32}, 64'hFFFFFFFF);
    chk("post_flush_reminder", {32'd0, r32}, 64'd0);
    release32();

    // flush together with in_valid in IDLE
    us32 = 1'b1; a32 = 32'd9; b32 = 32'd3; iv32 = 1'b1; fl32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv32 = 1'b0; fl32 = 1'b0;
    chk("flush_idle_not_accepted", {63'd0, bz32}, 64'd0);

    // random 32-bit operands against the model
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      bit rus;
      ra = $urandom;
      rb = (i % 8 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      rus = 1'($urandom_range(0, 1));
      model(32, rus, {32'd0, ra}, {32'd0, rb}, eq, er, edz, eov);
      run32(rus, ra, rb, lat, to);
      if (!to) begin
        chk("rnd32_quotient", {32'd0, q32}, eq);
        chk("rnd32_reminder", {32'd0, r32}, er);
        chk("rnd32_dbz", {63'd0, dz32}, {63'd0, edz});
      end
      release32();
    end

    // 8-bit boundary sweep, both modes
    edges[0] = 8'h00; edges[1] = 8'h01; edges[2] = 8'h02; edges[3] = 8'h7F;
    edges[4] = 8'h80; edges[5] = 8'h81; edges[6] = 8'hFE; edges[7] = 8'hFF;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          run8(m[0], edges[i], edges[j], 1'b0, 0);

    // 8-bit random with stalls and async resets
    for (int i = 0; i < 2500; i++) begin
      run8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 24) == 0), $urandom_range(0, 11));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
